// File: rtl/rv32_regfile_mp.sv
// rv32_regfile_mp: parametrised multi-port RV32 integer register file.
// Read addresses are latched; read data is combinational from storage, with
// optional same-cycle forwarding from the write ports. A per-register busy
// scoreboard tracks pending writes. After reset a sequencer zeroes every
// register one per clock, so the storage array carries no reset and can map
// onto block RAM.
module rv32_regfile_mp #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_in,
  input  logic                          writeback_flush_in,
  input  logic                          pipeline_flush_in,
  input  logic [READ_PORTS*AW-1:0]      rs_in,
  input  logic [WRITE_PORTS*AW-1:0]     rd_in,
  input  logic [WRITE_PORTS-1:0]        rd_write_in,
  input  logic [WRITE_PORTS*XLEN-1:0]   rd_value_in,
  input  logic                          issue_valid_in,
  input  logic [AW-1:0]                 issue_rd_in,
  output logic [READ_PORTS*XLEN-1:0]    rs_value_out,
  output logic [READ_PORTS-1:0]         rs_busy_out,
  output logic                          ready_out
);

  // INIT walks the clear index over every register; RUN is normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t            state;
  logic [AW-1:0]     clear_idx;
  logic [AW-1:0]     rs_lat   [READ_PORTS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [XLEN-1:0]   regs     [NREGS];

  logic [WRITE_PORTS-1:0] wr_eff;
  logic [AW-1:0]          wr_addr [WRITE_PORTS];
  logic [XLEN-1:0]        wr_data [WRITE_PORTS];

  // Unpack the write ports. A write is effective only in RUN, to a nonzero
  // register, and when the writeback stage has not been flushed.
  for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wport
    assign wr_addr[w] = rd_in[w*AW +: AW];
    assign wr_data[w] = rd_value_in[w*XLEN +: XLEN];
    assign wr_eff[w]  = (state == RUN) && rd_write_in[w] &&
                        (wr_addr[w] != '0) && !writeback_flush_in;
  end

  // Clearing sequencer: one register per clock, then RUN with ready raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      clear_idx <= '0;
      ready_out <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clear_idx == LAST_IDX) begin
            state     <= RUN;
            ready_out <= 1'b1;
            clear_idx <= '0;
          end else begin
            clear_idx <= clear_idx + AW'(1);
          end
        end
        RUN: begin
          ready_out <= 1'b1;
        end
        default: begin
          state     <= INIT;
          clear_idx <= '0;
          ready_out <= 1'b0;
        end
      endcase
    end
  end

  // Latch the read addresses in RUN unless the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        rs_lat[p] <= '0;
      end
    end else if (state == RUN && !stall_in) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        rs_lat[p] <= rs_in[p*AW +: AW];
      end
    end
  end

  // Storage writes: zeroing during INIT, port writes in RUN (higher port wins).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        regs[clear_idx] <= '0;
      end else begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (wr_eff[w]) begin
            regs[wr_addr[w]] <= wr_data[w];
          end
        end
      end
    end
  end

  // Scoreboard next state: writes clear, issue sets (set beats clear),
  // pipeline flush clears everything, and x0 is never busy.
  always_comb begin
    busy_next = busy;
    if (state == RUN) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_eff[w]) begin
          busy_next[wr_addr[w]] = 1'b0;
        end
      end
      if (issue_valid_in && issue_rd_in != '0) begin
        busy_next[issue_rd_in] = 1'b1;
      end
      if (pipeline_flush_in) begin
        busy_next = '0;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Read path: storage value from the latched address, overridden by a
  // same-cycle effective write when forwarding is enabled. The busy output
  // is the registered scoreboard bit, so same-cycle clears are not visible.
  always_comb begin
    rs_value_out = '0;
    rs_busy_out  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (state == RUN && rs_lat[p] != '0) begin
        rs_value_out[p*XLEN +: XLEN] = regs[rs_lat[p]];
        if (BYPASS != 0) begin
          for (int w = 0; w < WRITE_PORTS; w++) begin
            if (wr_eff[w] && wr_addr[w] == rs_lat[p]) begin
              rs_value_out[p*XLEN +: XLEN] = wr_data[w];
            end
          end
        end
        rs_busy_out[p] = busy[rs_lat[p]];
      end
    end
  end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// tb_rv32_regfile_mp: directed bench for rv32_regfile_mp. Two instances share
// every input: one with forwarding, one without, both with two write ports.
module tb_rv32_regfile_mp;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        writeback_flush_in;
  logic        pipeline_flush_in;
  logic [9:0]  rs_in;
  logic [9:0]  rd_in;
  logic [1:0]  rd_write_in;
  logic [63:0] rd_value_in;
  logic        issue_valid_in;
  logic [4:0]  issue_rd_in;

  logic [63:0] val_byp;
  logic [1:0]  busy_byp;
  logic        ready_byp;
  logic [63:0] val_nb;
  logic [1:0]  busy_nb;
  logic        ready_nb;

  int vectors;
  int miscompares;

  rv32_regfile_mp #(
    .XLEN(32), .NREGS(32), .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .writeback_flush_in(writeback_flush_in), .pipeline_flush_in(pipeline_flush_in),
    .rs_in(rs_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .rs_value_out(val_byp), .rs_busy_out(busy_byp), .ready_out(ready_byp)
  );

  rv32_regfile_mp #(
    .XLEN(32), .NREGS(32), .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .writeback_flush_in(writeback_flush_in), .pipeline_flush_in(pipeline_flush_in),
    .rs_in(rs_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
    .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
    .rs_value_out(val_nb), .rs_busy_out(busy_nb), .ready_out(ready_nb)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs0,
                               input logic [1:0] we,
                               input logic [4:0] rd1, input logic [4:0] rd0,
                               input logic [31:0] v1, input logic [31:0] v0);
    rs_in       = {rs1, rs0};
    rd_write_in = we;
    rd_in       = {rd1, rd0};
    rd_value_in = {v1, v0};
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst_n              = 1'b0;
    stall_in           = 1'b0;
    writeback_flush_in = 1'b0;
    pipeline_flush_in  = 1'b0;
    issue_valid_in     = 1'b0;
    issue_rd_in        = '0;
    applyStimulus(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Reset state
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_ready", {31'b0, ready_byp}, 32'h0);
    checkOutput("reset_val_p0", val_byp[31:0], 32'h0);
    checkOutput("reset_busy", {30'b0, busy_byp}, 32'h0);

    // Clearing sequence: ready rises on the 32nd edge with rst_n high
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checkOutput($sformatf("init_ready_%0d", i), {31'b0, ready_byp}, (i == 32) ? 32'h1 : 32'h0);
    end
    checkOutput("init_ready_nb", {31'b0, ready_nb}, 32'h1);

    // Freshly cleared registers read zero, nothing busy
    applyStimulus(5'd31, 5'd1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("clear_x1", val_byp[31:0], 32'h0);
    checkOutput("clear_x31", val_byp[63:32], 32'h0);
    checkOutput("clear_busy", {30'b0, busy_byp}, 32'h0);

    // Write x7, read {x7,x0} next cycle
    applyStimulus(5'd31, 5'd1, 2'b01, 5'd0, 5'd7, 32'h0, 32'h12345678);
    tick();
    applyStimulus(5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("x7_p1", val_byp[63:32], 32'h12345678);
    checkOutput("x0_p0", val_byp[31:0], 32'h0);
    checkOutput("x7_p1_nb", val_nb[63:32], 32'h12345678);

    // Write to x0 is ignored, and is not forwarded either
    applyStimulus(5'd7, 5'd0, 2'b01, 5'd0, 5'd0, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    checkOutput("x0_nofwd", val_byp[31:0], 32'h0);
    tick();
    applyStimulus(5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("x0_after_wr", val_byp[31:0], 32'h0);
    checkOutput("x0_after_wr_nb", val_nb[31:0], 32'h0);

    // Forwarding: latched x3, same-cycle write of x3
    applyStimulus(5'd7, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    applyStimulus(5'd7, 5'd3, 2'b01, 5'd0, 5'd3, 32'h0, 32'hA5A5A5A5);
    @(negedge clk);
    checkOutput("byp_same_cycle", val_byp[31:0], 32'hA5A5A5A5);
    checkOutput("nobyp_same_cycle", val_nb[31:0], 32'h0);
    tick();
    applyStimulus(5'd7, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("nobyp_next_cycle", val_nb[31:0], 32'hA5A5A5A5);
    checkOutput("byp_next_cycle", val_byp[31:0], 32'hA5A5A5A5);

    // Both ports write x9: higher port wins, in storage and on the bypass
    applyStimulus(5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    applyStimulus(5'd7, 5'd9, 2'b11, 5'd9, 5'd9, 32'h2, 32'h1);
    @(negedge clk);
    checkOutput("dual_byp", val_byp[31:0], 32'h2);
    tick();
    applyStimulus(5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("dual_x9", val_byp[31:0], 32'h2);
    checkOutput("dual_x9_nb", val_nb[31:0], 32'h2);

    // Writeback flush suppresses both writes and their forwarding
    writeback_flush_in = 1'b1;
    applyStimulus(5'd7, 5'd9, 2'b11, 5'd9, 5'd9, 32'h44, 32'h33);
    @(negedge clk);
    checkOutput("wbflush_nofwd", val_byp[31:0], 32'h2);
    tick();
    writeback_flush_in = 1'b0;
    applyStimulus(5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wbflush_x9", val_byp[31:0], 32'h2);
    checkOutput("wbflush_x9_nb", val_nb[31:0], 32'h2);

    // Issue x4 marks it busy
    applyStimulus(5'd7, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd4;
    tick();
    issue_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("issue_busy", {30'b0, busy_byp}, 32'h1);
    checkOutput("issue_busy_nb", {30'b0, busy_nb}, 32'h1);

    // Write x4 with simultaneous issue x4: stays busy; busy shown pre-edge
    applyStimulus(5'd7, 5'd4, 2'b01, 5'd0, 5'd4, 32'h0, 32'h44444444);
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd4;
    @(negedge clk);
    checkOutput("setclr_busy_pre", {30'b0, busy_byp}, 32'h1);
    checkOutput("setclr_byp", val_byp[31:0], 32'h44444444);
    tick();
    issue_valid_in = 1'b0;
    applyStimulus(5'd7, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("setclr_busy", {30'b0, busy_byp}, 32'h1);

    // Flushed write does not clear busy
    writeback_flush_in = 1'b1;
    applyStimulus(5'd7, 5'd4, 2'b01, 5'd0, 5'd4, 32'h0, 32'h55);
    tick();
    writeback_flush_in = 1'b0;
    applyStimulus(5'd7, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wbflush_busy", {30'b0, busy_byp}, 32'h1);
    checkOutput("wbflush_x4", val_byp[31:0], 32'h44444444);

    // Plain write clears busy
    applyStimulus(5'd7, 5'd4, 2'b01, 5'd0, 5'd4, 32'h0, 32'h66666666);
    tick();
    applyStimulus(5'd7, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("clr_busy", {30'b0, busy_byp}, 32'h0);
    checkOutput("clr_x4", val_byp[31:0], 32'h66666666);

    // Pipeline flush clears busy and overrides a same-cycle issue
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd4;
    tick();
    @(negedge clk);
    checkOutput("reissue_busy", {30'b0, busy_byp}, 32'h1);
    pipeline_flush_in = 1'b1;
    tick();
    pipeline_flush_in = 1'b0;
    issue_valid_in    = 1'b0;
    @(negedge clk);
    checkOutput("pflush_busy", {30'b0, busy_byp}, 32'h0);

    // Issue to x0 never marks it busy
    applyStimulus(5'd0, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd0;
    tick();
    issue_valid_in = 1'b0;
    @(negedge clk);
    checkOutput("x0_never_busy", {30'b0, busy_byp}, 32'h0);

    // Stall holds the latched address; writes still land
    applyStimulus(5'd0, 5'd0, 2'b11, 5'd2, 5'd1, 32'h22222222, 32'h11111111);
    tick();
    applyStimulus(5'd7, 5'd1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("pre_stall_x1", val_byp[31:0], 32'h11111111);
    stall_in = 1'b1;
    applyStimulus(5'd7, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("stall_hold", val_byp[31:0], 32'h11111111);
    checkOutput("stall_hold_nb", val_nb[31:0], 32'h11111111);
    applyStimulus(5'd7, 5'd2, 2'b01, 5'd0, 5'd1, 32'h0, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("stall_byp", val_byp[31:0], 32'hCAFEF00D);
    tick();
    applyStimulus(5'd7, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("stall_wr_nb", val_nb[31:0], 32'hCAFEF00D);
    stall_in = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("unstall_x2", val_byp[31:0], 32'h22222222);

    // Mid-run reset: x5 written and busy, then re-initialised
    applyStimulus(5'd7, 5'd2, 2'b01, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
    issue_valid_in = 1'b1;
    issue_rd_in    = 5'd5;
    tick();
    issue_valid_in = 1'b0;
    applyStimulus(5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("pre_rst_x5", val_byp[31:0], 32'hDEADBEEF);
    checkOutput("pre_rst_busy", {30'b0, busy_byp}, 32'h3);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midrst_ready", {31'b0, ready_byp}, 32'h0);
    checkOutput("midrst_val", val_byp[31:0], 32'h0);
    checkOutput("midrst_busy", {30'b0, busy_byp}, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checkOutput($sformatf("reinit_ready_%0d", i), {31'b0, ready_byp}, (i == 32) ? 32'h1 : 32'h0);
    end
    tick();
    @(negedge clk);
    checkOutput("reinit_x5", val_byp[31:0], 32'h0);
    checkOutput("reinit_x5_p1", val_byp[63:32], 32'h0);
    checkOutput("reinit_x5_nb", val_nb[31:0], 32'h0);
    checkOutput("reinit_busy", {30'b0, busy_byp}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32_regfile_mp.md
# rv32_regfile_mp

Parametrised multi-port integer register file for the RV32 core family, replacing the fixed 2-read/1-write file in the decode/writeback path. It supports configurable XLEN, register count (32 for RV32I, 16 for RV32E), read-port count and write-port count. It adds writeback-to-read bypass, a per-register pending-write scoreboard, and a reset-time clearing sequencer so storage can map to block RAM.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, architectural register count (16 or 32); AW = $clog2(NREGS)
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 1, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- stall_in  in  1  hold latched read addresses
- writeback_flush_in  in  1  suppress all writes and their busy clears this cycle
- pipeline_flush_in  in  1  clear every busy bit
- rs_in  in  READ_PORTS*AW  packed read addresses, port p at [p*AW +: AW]
- rd_in  in  WRITE_PORTS*AW  packed write addresses
- rd_write_in  in  WRITE_PORTS  per-port write enable
- rd_value_in  in  WRITE_PORTS*XLEN  packed write data
- issue_valid_in  in  1  mark issue_rd_in as pending-write
- issue_rd_in  in  AW  destination of issuing instruction
- rs_value_out  out  READ_PORTS*XLEN  packed read data
- rs_busy_out  out  READ_PORTS  busy bit of each latched read address
- ready_out  out  1  1 = clearing done, file operational

## Operation
- States INIT and RUN. rst_n low: state=INIT, clear index=0, latched read addresses=0, all busy bits=0, ready_out=0.
- INIT: each rising edge with rst_n high writes 0 to regs[index] and increments index. When index=NREGS-1 is written, the state moves to RUN.
- INIT (cont.): rd/issue/stall inputs are ignored. rs_value_out=0, rs_busy_out=0.
- RUN: if !stall_in, latch rs_in. rs_value_out[p] = regs[latched_rs[p]], combinational from the latched address.
- Write: port w is effective iff rd_write_in[w] && rd_in[w]!=0 && !writeback_flush_in. When two effective ports target the same rd, the higher port index wins.
- Register 0 always reads 0, is never written and is never busy.
- Bypass (BYPASS=1): if an effective write targets latched_rs[p] in the current cycle, rs_value_out[p] = that port's rd_value_in (highest matching port), same cycle. BYPASS=0: the new value is visible from the next cycle.
- Busy set: issue_valid_in && issue_rd_in!=0 sets busy[issue_rd_in].
- Busy clear: an effective write clears busy[rd]. A simultaneous set and clear of the same register leaves it set.
- pipeline_flush_in clears all busy bits and overrides a same-cycle set.
- rs_busy_out[p] = busy[latched_rs[p]] as registered, i.e. the pre-edge value. Same-cycle clears are not forwarded; bypass covers the data.

## Timing
- ready_out rises exactly NREGS rising edges after the first edge sampling rst_n=1.
- rst_n low in RUN: next edge returns to INIT, contents re-zeroed, busy cleared, ready_out=0 the following cycle.
- Read latency: address latched at edge N, data valid after edge N (combinational from storage).
- Write latency: data written at edge N, readable without bypass after edge N.
- Stall holds addresses only. Writes and busy updates proceed during stall.

## Test plan
- Reset release, NREGS=32 -> ready_out=0 for 32 cycles, 1 on cycle 33. All reads 0, all busy 0. Repeat with a mid-run reset -> a previously written x5=0xDEADBEEF reads 0 after re-init.
- RUN: write x7=0x12345678, next cycle rs_in={x7,x0} -> rs_value_out={0x12345678,0}. Write to x0 with 0xFFFFFFFF -> x0 still reads 0.
- BYPASS=1: latched rs=x3, same-cycle write x3=0xA5A5A5A5 -> output 0xA5A5A5A5 that cycle. BYPASS=0 -> old value that cycle, new value the next.
- WRITE_PORTS=2, both ports write x9 (0x1, 0x2) -> x9=0x2. Same with writeback_flush_in=1 -> x9 unchanged.
- Issue x4 -> rs_busy_out=1 for x4. Effective write x4 with issue x4 in the same cycle -> stays busy. pipeline_flush_in -> busy 0 next cycle.
- stall_in=1 while rs_in changes from x1 to x2 -> output tracks x1. A write to x1 during the stall is visible on the held port.
